// File: rtl/cacheline_burst_adapter.sv
// ---------------------------------------------------------------------------
// cacheline_burst_adapter
//
// Converts one cache-line read or write request into a burst of BEATS
// memory beats of BURST_W bits each, and reports completion with a single
// cycle line_resp pulse.
//
// Parameters
//   LINE_W   cache line width in bits
//   BURST_W  memory beat width in bits (BEATS = LINE_W/BURST_W, >= 2)
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   line_addr      line address from the eviction/write-buffer stage
//   line_wdata     line to write
//   line_rdata     assembled read line (valid in DONE, held until next read)
//   line_read      line read request (level, held until line_resp)
//   line_write     line write request (level, held until line_resp)
//   line_resp      one-cycle completion pulse
//   mem_addr       burst base address (line aligned)
//   mem_rdata      read beat
//   mem_wdata      write beat
//   mem_read       burst read active
//   mem_write      burst write active
//   mem_resp       beat accepted / valid this cycle
// ---------------------------------------------------------------------------
module cacheline_burst_adapter #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         line_addr,
    input  logic [LINE_W-1:0]   line_wdata,
    output logic [LINE_W-1:0]   line_rdata,
    input  logic                line_read,
    input  logic                line_write,
    output logic                line_resp,
    output logic [31:0]         mem_addr,
    input  logic [BURST_W-1:0]  mem_rdata,
    output logic [BURST_W-1:0]  mem_wdata,
    output logic                mem_read,
    output logic                mem_write,
    input  logic                mem_resp
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);

    // Clears the byte-offset bits inside a line so bursts start line aligned.
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_addr;
    logic [LINE_W-1:0] r_wline;
    logic [LINE_W-1:0] r_rdata;

    logic              w_last_beat;

    assign w_last_beat = (r_cnt == LAST_BEAT);

    // NOTE: every register here, including the two line-wide data registers,
    // is in the async reset list because the outputs derived from them must
    // read zero while rst_n is low; the line registers are flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wline <= '0;
            r_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based
            // on the values present before this edge, whatever the order below.
            case (r_state)
                S_IDLE: begin
                    // Read takes priority when both requests are raised.
                    if (line_read) begin
                        r_addr  <= line_addr & ADDR_MASK;
                        r_cnt   <= '0;
                        r_state <= S_READ;
                    end else if (line_write) begin
                        r_addr  <= line_addr & ADDR_MASK;
                        r_wline <= line_wdata;
                        r_cnt   <= '0;
                        r_state <= S_WRITE;
                    end
                end

                S_READ: begin
                    // mem_resp low stalls: nothing changes.
                    if (mem_resp) begin
                        r_rdata[r_cnt*BURST_W +: BURST_W] <= mem_rdata;
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                S_WRITE: begin
                    if (mem_resp) begin
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    // DONE: a single cycle of line_resp, mem_resp ignored.
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so they follow the
    // asynchronous reset immediately and carry no combinational input paths.
    assign mem_addr   = r_addr;
    assign mem_read   = (r_state == S_READ);
    assign mem_write  = (r_state == S_WRITE);
    assign line_resp  = (r_state == S_DONE);
    assign mem_wdata  = r_wline[r_cnt*BURST_W +: BURST_W];
    assign line_rdata = r_rdata;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// ---------------------------------------------------------------------------
// tb_cacheline_burst_adapter
//
// Directed bench for cacheline_burst_adapter with LINE_W=256, BURST_W=64
// (four beats). Inputs change 1 ns after the rising edge and outputs are
// sampled at the same point, so each "cycle" below is the state the DUT
// holds between two rising edges.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cacheline_burst_adapter;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;

    logic               clk;
    logic               rst_n;
    logic [31:0]        line_addr;
    logic [LINE_W-1:0]  line_wdata;
    logic [LINE_W-1:0]  line_rdata;
    logic               line_read;
    logic               line_write;
    logic               line_resp;
    logic [31:0]        mem_addr;
    logic [BURST_W-1:0] mem_rdata;
    logic [BURST_W-1:0] mem_wdata;
    logic               mem_read;
    logic               mem_write;
    logic               mem_resp;

    int n_pass;
    int n_total;

    cacheline_burst_adapter #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_addr  (line_addr),
        .line_wdata (line_wdata),
        .line_rdata (line_rdata),
        .line_read  (line_read),
        .line_write (line_write),
        .line_resp  (line_resp),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_resp   (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read burst: request raised in the current (IDLE) cycle. stall[i] low
    // means mem_resp high in the i-th cycle after the request. Returns in the
    // IDLE cycle following DONE with both requests low.
    task automatic run_read(input logic [31:0] addr, input logic [LINE_W-1:0] line,
                            input logic [15:0] stall, input logic both,
                            output int n_cycles);
        int b;
        int cyc;
        line_addr  = addr;
        line_read  = 1'b1;
        line_write = both;
        mem_resp   = 1'b1;      // ignored in IDLE
        mem_rdata  = '1;
        n_total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || line_resp !== 1'b0)
            $display("FAIL rd_idle: got rd=%b wr=%b resp=%b, required 0 0 0", mem_read, mem_write, line_resp);
        else n_pass++;
        b = 0;
        cyc = 0;
        while (b < 4 && cyc < 16) begin
            tick();
            line_addr = ~addr;   // must not disturb the burst
            mem_resp  = !stall[cyc];
            mem_rdata = mem_resp ? line[b*BURST_W +: BURST_W] : 64'hDEAD_BEEF_DEAD_BEEF;
            n_total++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || line_resp !== 1'b0 ||
                mem_addr !== (addr & 32'hFFFF_FFE0))
                $display("FAIL rd_beat%0d: got rd=%b wr=%b resp=%b addr=%h, required 1 0 0 %h",
                         cyc, mem_read, mem_write, line_resp, mem_addr, addr & 32'hFFFF_FFE0);
            else n_pass++;
            if (mem_resp) b++;
            cyc++;
        end
        n_cycles = cyc;
        tick();                  // DONE
        mem_resp   = 1'b1;       // ignored in DONE
        mem_rdata  = 64'h5555_AAAA_5555_AAAA;
        line_read  = 1'b0;
        line_write = 1'b0;
        n_total++;
        if (line_resp !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL rd_done: got resp=%b rd=%b wr=%b, required 1 0 0", line_resp, mem_read, mem_write);
        else n_pass++;
        n_total++;
        if (line_rdata !== line)
            $display("FAIL rd_data: got %h, required %h", line_rdata, line);
        else n_pass++;
        tick();                  // IDLE
        mem_resp = 1'b0;
        n_total++;
        if (line_resp !== 1'b0 || mem_read !== 1'b0 || line_rdata !== line)
            $display("FAIL rd_after: got resp=%b rd=%b data=%h, required 0 0 %h",
                     line_resp, mem_read, line_rdata, line);
        else n_pass++;
    endtask

    // Write burst, same framing as run_read. keep is the line_rdata value
    // that must survive the write untouched.
    task automatic run_write(input logic [31:0] addr, input logic [LINE_W-1:0] wline,
                             input logic [15:0] stall, input logic [LINE_W-1:0] keep,
                             output int n_cycles);
        int b;
        int cyc;
        logic [BURST_W-1:0] exp_beat;
        line_addr  = addr;
        line_wdata = wline;
        line_write = 1'b1;
        line_read  = 1'b0;
        mem_resp   = 1'b0;
        n_total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || line_resp !== 1'b0)
            $display("FAIL wr_idle: got rd=%b wr=%b resp=%b, required 0 0 0", mem_read, mem_write, line_resp);
        else n_pass++;
        b = 0;
        cyc = 0;
        while (b < 4 && cyc < 16) begin
            tick();
            line_addr  = ~addr;
            line_wdata = ~wline;
            mem_resp   = !stall[cyc];
            exp_beat   = wline[b*BURST_W +: BURST_W];
            n_total++;
            if (mem_write !== 1'b1 || mem_read !== 1'b0 || line_resp !== 1'b0 ||
                mem_addr !== (addr & 32'hFFFF_FFE0) || mem_wdata !== exp_beat)
                $display("FAIL wr_beat%0d: got wr=%b rd=%b resp=%b addr=%h wdata=%h, required 1 0 0 %h %h",
                         cyc, mem_write, mem_read, line_resp, mem_addr, mem_wdata,
                         addr & 32'hFFFF_FFE0, exp_beat);
            else n_pass++;
            n_total++;
            if (line_rdata !== keep)
                $display("FAIL wr_keep%0d: got %h, required %h", cyc, line_rdata, keep);
            else n_pass++;
            if (mem_resp) b++;
            cyc++;
        end
        n_cycles = cyc;
        tick();                  // DONE
        mem_resp   = 1'b0;
        line_write = 1'b0;
        n_total++;
        if (line_resp !== 1'b1 || mem_write !== 1'b0 || mem_read !== 1'b0 || line_rdata !== keep)
            $display("FAIL wr_done: got resp=%b wr=%b rd=%b data=%h, required 1 0 0 %h",
                     line_resp, mem_write, mem_read, line_rdata, keep);
        else n_pass++;
        tick();                  // IDLE
        n_total++;
        if (line_resp !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL wr_after: got resp=%b wr=%b, required 0 0", line_resp, mem_write);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        line_addr  = 32'hFFFF_FFFF;
        line_wdata = '1;
        line_read  = 1'b1;       // must be ignored while in reset
        line_write = 1'b0;
        mem_rdata  = '1;
        mem_resp   = 1'b1;
        #3;
        n_total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || line_resp !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 64'h0 || line_rdata !== '0)
            $display("FAIL reset_state: got rd=%b wr=%b resp=%b addr=%h wdata=%h rdata=%h, required all 0",
                     mem_read, mem_write, line_resp, mem_addr, mem_wdata, line_rdata);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (mem_read !== 1'b0 || line_resp !== 1'b0 || mem_addr !== 32'h0)
            $display("FAIL reset_hold: got rd=%b resp=%b addr=%h, required 0 0 0", mem_read, line_resp, mem_addr);
        else n_pass++;
        line_read = 1'b0;
        mem_resp  = 1'b0;
        rst_n     = 1'b1;
        tick();
        n_total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || line_resp !== 1'b0)
            $display("FAIL reset_release: got rd=%b wr=%b resp=%b, required 0 0 0", mem_read, mem_write, line_resp);
        else n_pass++;
    endtask

    task automatic test_read_no_stall(output logic [LINE_W-1:0] got_line);
        logic [LINE_W-1:0] line;
        int n;
        line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run_read(32'h0000_1234, line, 16'h0000, 1'b0, n);
        n_total++;
        if (n !== 4)
            $display("FAIL read_latency: got %0d beat cycles, required 4", n);
        else n_pass++;
        got_line = line;
    endtask

    task automatic test_write_stall(input logic [LINE_W-1:0] keep);
        logic [LINE_W-1:0] wline;
        int n;
        wline = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        // stalls in cycles 2 and 3 after the request
        run_write(32'h0000_ABFF, wline, 16'b0000_0000_0000_0110, keep, n);
        n_total++;
        if (n !== 6)
            $display("FAIL write_latency: got %0d beat cycles, required 6 (line_resp at cycle 7)", n);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [LINE_W-1:0] line;
        int n;
        line = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_2468_ACE0};
        run_read(32'h8000_0047, line, 16'h0000, 1'b1, n);
        n_total++;
        if (n !== 4)
            $display("FAIL simul_latency: got %0d beat cycles, required 4", n);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst(output logic [LINE_W-1:0] got_line);
        logic [LINE_W-1:0] line;
        int n;
        line_addr = 32'h2000_0040;
        line_read = 1'b1;
        tick();                  // cycle 1: first beat
        mem_resp  = 1'b1;
        mem_rdata = 64'h9999_9999_9999_9999;
        tick();                  // cycle 2
        n_total++;
        if (mem_read !== 1'b1 || line_rdata[63:0] !== 64'h9999_9999_9999_9999)
            $display("FAIL mid_beat: got rd=%b beat0=%h, required 1 9999999999999999", mem_read, line_rdata[63:0]);
        else n_pass++;
        rst_n     = 1'b0;
        line_read = 1'b0;
        mem_resp  = 1'b0;
        #1;
        n_total++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || line_resp !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 64'h0 || line_rdata !== '0)
            $display("FAIL mid_reset: got rd=%b wr=%b resp=%b addr=%h wdata=%h rdata=%h, required all 0",
                     mem_read, mem_write, line_resp, mem_addr, mem_wdata, line_rdata);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if (line_resp !== 1'b0)
                $display("FAIL mid_noresp%0d: got resp=%b, required 0", i, line_resp);
            else n_pass++;
        end
        rst_n = 1'b1;
        tick();
        line = {{4{16'hC0DE}}, {4{16'hBEEF}}, {4{16'hCAFE}}, {4{16'hF00D}}};
        run_read(32'h2000_0040, line, 16'h0000, 1'b0, n);
        got_line = line;
    endtask

    task automatic test_back_to_back(input logic [LINE_W-1:0] keep);
        logic [LINE_W-1:0] wline;
        logic [LINE_W-1:0] rline;
        int n;
        wline = {64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0002,
                 64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0000};
        rline = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                 64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
        run_write(32'h0000_4000, wline, 16'h0000, keep, n);
        // The read is raised in the first IDLE cycle after DONE and must be
        // accepted there.
        run_read(32'h0000_4020, rline, 16'b0000_0000_0000_0100, 1'b0, n);
        n_total++;
        if (n !== 5)
            $display("FAIL b2b_latency: got %0d beat cycles, required 5", n);
        else n_pass++;
    endtask

    initial begin
        logic [LINE_W-1:0] last_line;
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_read_no_stall(last_line);
        test_write_stall(last_line);
        test_simultaneous();
        test_reset_mid_burst(last_line);
        test_back_to_back(last_line);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cacheline_burst_adapter.md
CACHELINE_BURST_ADAPTER -- requirements
Module: cacheline_burst_adapter

Interface
REQ-001 SHALL have parameter LINE_W, default 256: cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64: memory beat width in bits; BEATS = LINE_W/BURST_W, integer and >= 2.
REQ-003 SHALL have one clock and an asynchronous active-low reset; both port lines follow.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port line_addr, input, 32: line address from the eviction/write-buffer stage.
REQ-007 SHALL have port line_wdata, input, LINE_W: line to write.
REQ-008 SHALL have port line_rdata, output, LINE_W: assembled read line.
REQ-009 SHALL have port line_read, input, 1: line read request, level, held until line_resp.
REQ-010 SHALL have port line_write, input, 1: line write request, level, held until line_resp.
REQ-011 SHALL have port line_resp, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port mem_addr, output, 32: burst base address.
REQ-013 SHALL have port mem_rdata, input, BURST_W: read beat.
REQ-014 SHALL have port mem_wdata, output, BURST_W: write beat.
REQ-015 SHALL have port mem_read, output, 1: burst read active.
REQ-016 SHALL have port mem_write, output, 1: burst write active.
REQ-017 SHALL have port mem_resp, input, 1: beat accepted or valid this cycle.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE and DONE.
REQ-019 In IDLE with line_read=1, SHALL latch line_addr into the address register, clear the beat counter, and go to READ; line_read SHALL win if both requests are high.
REQ-020 In IDLE with only line_write=1, SHALL latch line_addr and line_wdata, clear the beat counter, and go to WRITE.
REQ-021 The latched address SHALL have its low log2(LINE_W/8) bits forced to zero; mem_addr SHALL equal the latched address in every state.
REQ-022 SHALL drive mem_read=1 only in READ and mem_write=1 only in WRITE; both SHALL be held for the whole burst.
REQ-023 In READ, each cycle with mem_resp=1 SHALL store mem_rdata into line_rdata slice [cnt*BURST_W +: BURST_W], then increment cnt.
REQ-024 In WRITE, mem_wdata SHALL equal slice cnt of the latched line, with beat 0 = bits [BURST_W-1:0]; each cycle with mem_resp=1 SHALL increment cnt.
REQ-025 mem_resp=0 SHALL stall the burst: cnt, data and state hold, with no timeout.
REQ-026 On the beat where cnt=BEATS-1 and mem_resp=1, SHALL go to DONE; cnt SHALL then wrap to 0.
REQ-027 In DONE, SHALL assert line_resp=1 for exactly one cycle, then go to IDLE.
REQ-028 line_rdata SHALL be valid in DONE and hold until the next READ beat overwrites it; WRITE SHALL NOT modify it.
REQ-029 mem_resp SHALL be ignored in IDLE and DONE.
REQ-030 line_read and line_write SHALL be sampled only in IDLE; the requester SHALL deassert both in the cycle after line_resp.
REQ-031 Latency with no stalls: request seen in IDLE at cycle 0, beats at cycles 1..BEATS, line_resp at cycle BEATS+1; the next request SHALL be accepted at cycle BEATS+2.
REQ-032 Input changes on line_addr or line_wdata during a burst SHALL NOT affect it.

Reset
REQ-033 While rst_n=0, asynchronously: state=IDLE, cnt=0, address register=0, write-line register=0, line_rdata=0, line_resp=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset asserted mid-burst SHALL abort the burst with no line_resp; after release the block SHALL be in IDLE and accept a new request.

Verification
REQ-035 Read, no stall: line_read, addr 0x0000_1234, mem_resp high for beats 0x11..,0x22..,0x33..,0x44.. -> mem_addr=0x0000_1220, mem_read high cycles 1-4, line_resp at cycle 5, line_rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-036 Write with stall: line_write, line_wdata=0xDDDD..CCCC..BBBB..AAAA.., mem_resp low cycles 2-3 -> mem_wdata sequence AAAA, BBBB (held 3 cycles), CCCC, DDDD, line_resp at cycle 7.
REQ-037 Simultaneous line_read and line_write in IDLE -> READ burst only, mem_write stays 0.
REQ-038 Reset at cycle 2 of a read -> all outputs 0 immediately, no line_resp; a following read completes normally.
REQ-039 Back-to-back: write then read, requests dropped after each line_resp -> second burst starts one cycle after DONE, and line_rdata is untouched by the write.
